// File: rtl/arm_multicycle_mainfsm_if.sv
// Control bus between the multicycle ARM main FSM and its datapath.
// The FSM side (master) takes the instruction fields and the memory
// completion strobe, and drives every mux select and write strobe.
//
// Handshake: MemReady is a single-cycle completion flag from memory.
// In FETCH, MEMREAD and MEMWRITE the FSM holds the current access
// (address select and MemW) until it samples MemReady=1 on a clock
// edge. That edge retires the access and the FSM moves on. No other
// state looks at MemReady.
interface arm_multicycle_mainfsm_if #(
   parameter int CNT_W = 32
);
   logic [1:0]       Op;
   logic [5:0]       Funct;
   logic             MemReady;
   logic             IRWrite;
   logic             NextPC;
   logic             AdrSrc;
   logic [1:0]       ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic             ALUOp;
   logic [1:0]       ResultSrc;
   logic             RegW;
   logic             MemW;
   logic             Branch;
   logic             Fault;
   logic [3:0]       State;
   logic [CNT_W-1:0] InstrCount;

   modport master (
      input  Op, Funct, MemReady,
      output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc,
             RegW, MemW, Branch, Fault, State, InstrCount
   );

   modport slave (
      output Op, Funct, MemReady,
      input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc,
             RegW, MemW, Branch, Fault, State, InstrCount
   );
endinterface

// File: rtl/arm_multicycle_mainfsm.sv
// Main control FSM for the multicycle ARM datapath.
// It sequences fetch, decode, execute, memory and writeback for
// data-processing, LDR/STR and B instructions. The outputs are Moore
// outputs decoded from the state. The exceptions are IRWrite/NextPC in
// FETCH, which follow MemReady.
// The write strobes are raw: the conditional logic downstream gates
// them. While reset is low they are also forced to 0.
module arm_multicycle_mainfsm #(
   parameter int CNT_W = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   arm_multicycle_mainfsm_if.master  bus
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      UNKNOWN  = 4'd10
   } state_t;

   state_t           stateQ;
   state_t           stateNext;
   logic             faultQ;
   logic [CNT_W-1:0] countQ;

   // Raw Moore outputs, before the reset gating of the strobes.
   logic       irWriteRaw;
   logic       nextPcRaw;
   logic       adrSrc;
   logic [1:0] aluSrcA;
   logic [1:0] aluSrcB;
   logic       aluOp;
   logic [1:0] resultSrc;
   logic       regWRaw;
   logic       memWRaw;
   logic       branchRaw;

   // State register, sticky fault flag and retired-instruction counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         stateQ <= FETCH;
         faultQ <= 1'b0;
         countQ <= '0;
      end else begin
         stateQ <= stateNext;
         if (stateNext == UNKNOWN) begin
            faultQ <= 1'b1;
         end
         if ((stateQ == FETCH) && bus.MemReady) begin
            countQ <= countQ + CNT_W'(1);
         end
      end
   end

   // Next-state logic. Op/Funct are only looked at in DECODE and MEMADR.
   always_comb begin
      stateNext = stateQ;
      case (stateQ)
         FETCH:    if (bus.MemReady) stateNext = DECODE;
         DECODE: begin
            case (bus.Op)
               2'b00:   stateNext = bus.Funct[5] ? EXECUTEI : EXECUTER;
               2'b01:   stateNext = MEMADR;
               2'b10:   stateNext = BRANCH;
               default: stateNext = UNKNOWN;
            endcase
         end
         MEMADR:   stateNext = bus.Funct[0] ? MEMREAD : MEMWRITE;
         MEMREAD:  if (bus.MemReady) stateNext = MEMWB;
         MEMWRITE: if (bus.MemReady) stateNext = FETCH;
         MEMWB:    stateNext = FETCH;
         EXECUTER: stateNext = ALUWB;
         EXECUTEI: stateNext = ALUWB;
         ALUWB:    stateNext = FETCH;
         BRANCH:   stateNext = FETCH;
         UNKNOWN:  stateNext = UNKNOWN;
         default:  stateNext = UNKNOWN;
      endcase
   end

   // Output decode. Every output defaults to 0, so UNKNOWN and the
   // unused codes drive nothing.
   always_comb begin
      irWriteRaw = 1'b0;
      nextPcRaw  = 1'b0;
      adrSrc     = 1'b0;
      aluSrcA    = 2'b00;
      aluSrcB    = 2'b00;
      aluOp      = 1'b0;
      resultSrc  = 2'b00;
      regWRaw    = 1'b0;
      memWRaw    = 1'b0;
      branchRaw  = 1'b0;
      case (stateQ)
         FETCH: begin
            aluSrcA    = 2'b01;
            aluSrcB    = 2'b10;
            resultSrc  = 2'b10;
            irWriteRaw = bus.MemReady;
            nextPcRaw  = bus.MemReady;
         end
         DECODE: begin
            aluSrcA   = 2'b01;
            aluSrcB   = 2'b10;
            resultSrc = 2'b10;
         end
         MEMADR: begin
            aluSrcA = 2'b00;
            aluSrcB = 2'b01;
         end
         MEMREAD: begin
            adrSrc = 1'b1;
         end
         MEMWB: begin
            resultSrc = 2'b01;
            regWRaw   = 1'b1;
         end
         MEMWRITE: begin
            adrSrc  = 1'b1;
            memWRaw = 1'b1;
         end
         EXECUTER: begin
            aluSrcB = 2'b00;
            aluOp   = 1'b1;
         end
         EXECUTEI: begin
            aluSrcB = 2'b01;
            aluOp   = 1'b1;
         end
         ALUWB: begin
            regWRaw = 1'b1;
         end
         BRANCH: begin
            aluSrcA   = 2'b10;
            aluSrcB   = 2'b01;
            resultSrc = 2'b10;
            branchRaw = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // While reset is low, the strobes are gated off. An aborted access
   // then cannot write anything in the cycle before the reset edge.
   assign bus.IRWrite    = irWriteRaw & reset;
   assign bus.NextPC     = nextPcRaw & reset;
   assign bus.RegW       = regWRaw & reset;
   assign bus.MemW       = memWRaw & reset;
   assign bus.Branch     = branchRaw & reset;
   assign bus.AdrSrc     = adrSrc;
   assign bus.ALUSrcA    = aluSrcA;
   assign bus.ALUSrcB    = aluSrcB;
   assign bus.ALUOp      = aluOp;
   assign bus.ResultSrc  = resultSrc;
   assign bus.Fault      = faultQ;
   assign bus.State      = stateQ;
   assign bus.InstrCount = countQ;

endmodule

// File: tb/tb_arm_multicycle_mainfsm.sv
// Directed bench for arm_multicycle_mainfsm.
// Each planned cycle pushes its stimulus (MemReady, reset) and its
// expected output vector and InstrCount onto queues. run() then
// replays the stimulus and, at each negedge, compares the DUT outputs
// with the values popped from the queues.
module tb_arm_multicycle_mainfsm;
   localparam int CNT_W = 32;

   logic clk;
   logic reset;

   arm_multicycle_mainfsm_if #(.CNT_W(CNT_W)) bus ();

   arm_multicycle_mainfsm #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Clock and reset.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard queues and counters.
   logic [17:0]      exp_q[$];
   logic [CNT_W-1:0] cnt_q[$];
   logic [1:0]       stim_q[$];
   logic [CNT_W-1:0] cnt_model;
   int               checks;
   int               errors;
   int               cyc;

   // Expected outputs for one cycle, taken from the state output table.
   // Vector layout: {State, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB,
   // ALUOp, ResultSrc, RegW, MemW, Branch, Fault}.
   function automatic logic [17:0] ctl(input logic [3:0] st, input logic mr,
                                       input logic rn, input logic flt);
      logic irw, npc, adr, aop, regw, memw, br;
      logic [1:0] sa, sb, rs;
      irw = 0; npc = 0; adr = 0; aop = 0; regw = 0; memw = 0; br = 0;
      sa = 2'b00; sb = 2'b00; rs = 2'b00;
      case (st)
         4'd0: begin irw = mr & rn; npc = mr & rn; sa = 2'b01; sb = 2'b10; rs = 2'b10; end
         4'd1: begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
         4'd2: begin sa = 2'b00; sb = 2'b01; end
         4'd3: begin adr = 1; end
         4'd4: begin rs = 2'b01; regw = rn; end
         4'd5: begin adr = 1; memw = rn; end
         4'd6: begin aop = 1; end
         4'd7: begin sb = 2'b01; aop = 1; end
         4'd8: begin regw = rn; end
         4'd9: begin sa = 2'b10; sb = 2'b01; rs = 2'b10; br = rn; end
         default: begin end
      endcase
      return {st, irw, npc, adr, sa, sb, aop, rs, regw, memw, br, flt};
   endfunction

   // Driver: queue one cycle of stimulus together with its expectations.
   task automatic plan(input logic [3:0] st, input logic mr, input logic rn,
                       input logic flt);
      exp_q.push_back(ctl(st, mr, rn, flt));
      cnt_q.push_back(cnt_model);
      stim_q.push_back({mr, rn});
      if (!rn) cnt_model = '0;
      else if ((st == 4'd0) && mr) cnt_model = cnt_model + 1;
   endtask

   // Driver and checker: apply the queued cycles, starting at a negedge.
   task automatic run();
      logic [1:0]       s;
      logic [17:0]      e;
      logic [17:0]      obs;
      logic [CNT_W-1:0] c;
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         bus.MemReady = s[1];
         reset = s[0];
         #1;
         e = exp_q.pop_front();
         c = cnt_q.pop_front();
         obs = {bus.State, bus.IRWrite, bus.NextPC, bus.AdrSrc, bus.ALUSrcA,
                bus.ALUSrcB, bus.ALUOp, bus.ResultSrc, bus.RegW, bus.MemW,
                bus.Branch, bus.Fault};
         checks++;
         assert (obs === e) else begin
            errors++;
            $error("FAIL ctl cycle %0d: observed %05h expected %05h", cyc, obs, e);
         end
         checks++;
         assert (bus.InstrCount === c) else begin
            errors++;
            $error("FAIL InstrCount cycle %0d: observed %0d expected %0d",
                   cyc, bus.InstrCount, c);
         end
         cyc++;
         @(negedge clk);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc = 0;
      cnt_model = '0;
      reset = 1'b0;
      bus.MemReady = 1'b1;
      bus.Op = 2'b00;
      bus.Funct = 6'b001000;
      @(negedge clk);

      // Reset state: FETCH selects, strobes forced off.
      plan(0, 1, 0, 0);
      run();

      // ADD: 0,1,6,8 then FETCH.
      bus.Op = 2'b00; bus.Funct = 6'b001000;
      plan(0, 1, 1, 0); plan(1, 1, 1, 0); plan(6, 1, 1, 0); plan(8, 1, 1, 0);
      run();

      // LDR: 0,1,2,3,4.
      bus.Op = 2'b01; bus.Funct = 6'b011001;
      plan(0, 1, 1, 0); plan(1, 1, 1, 0); plan(2, 1, 1, 0); plan(3, 1, 1, 0);
      plan(4, 1, 1, 0);
      run();

      // STR that stalls in MEMWRITE for 3 cycles: MemW is held for 4 cycles.
      bus.Op = 2'b01; bus.Funct = 6'b011000;
      plan(0, 1, 1, 0); plan(1, 1, 1, 0); plan(2, 1, 1, 0);
      plan(5, 0, 1, 0); plan(5, 0, 1, 0); plan(5, 0, 1, 0); plan(5, 1, 1, 0);
      run();

      // B, with a FETCH stall of 2 cycles first.
      bus.Op = 2'b10; bus.Funct = 6'b100000;
      plan(0, 0, 1, 0); plan(0, 0, 1, 0); plan(0, 1, 1, 0); plan(1, 1, 1, 0);
      plan(9, 1, 1, 0);
      run();

      // STR aborted by reset while in MEMWRITE: no MemW pulse afterwards.
      bus.Op = 2'b01; bus.Funct = 6'b011000;
      plan(0, 1, 1, 0); plan(1, 1, 1, 0); plan(2, 1, 1, 0); plan(5, 0, 1, 0);
      plan(5, 0, 0, 0); plan(0, 0, 1, 0); plan(0, 0, 1, 0);
      run();

      // Undefined opcode: UNKNOWN is sticky, then cleared by reset.
      bus.Op = 2'b11; bus.Funct = 6'b000000;
      plan(0, 1, 1, 0); plan(1, 1, 1, 0);
      for (int i = 0; i < 20; i++) plan(10, 1'($urandom_range(0, 1)), 1, 1);
      plan(10, 1, 0, 1);
      plan(0, 0, 1, 0);
      run();

      // Immediate data-processing: 0,1,7,8 then FETCH.
      bus.Op = 2'b00; bus.Funct = 6'b101000;
      plan(0, 1, 1, 0); plan(1, 1, 1, 0); plan(7, 1, 1, 0); plan(8, 1, 1, 0);
      plan(0, 0, 1, 0);
      run();

      // Final report.
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
